jtag_reg_access: RTL and testbench
==================================

# jtag_reg_access

Debug-side access controller for the core's general-purpose register file. It accepts single read/write commands from the JTAG DTM over a valid/ready request channel and optionally halts the core first. It then drives the register file's JTAG port (write enable, address, write data, read data), retries writes that lose arbitration to the execute stage, and returns one response per command on a valid/ready response channel.

## Interface
Parameters:
- `RETRY_MAX`, default 15: write retries allowed after losing to an execute-stage write before an error is reported.
- `HALT_TIMEOUT`, default 255: cycles to wait for `halt_ack_i` before an error is reported.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid_i` in 1: DTM command valid.
- `req_ready_o` out 1: block can accept a command.
- `req_we_i` in 1: 1 = write, 0 = read.
- `req_addr_i` in 5: register index.
- `req_data_i` in 32: write data.
- `resp_valid_o` out 1: response valid.
- `resp_ready_i` in 1: DTM accepts the response.
- `resp_data_o` out 32: read data; echo of write data; 0 on error.
- `resp_err_o` out 1: command failed (timeout or retries exhausted).
- `halt_req_o` out 1: request core halt.
- `halt_ack_i` in 1: core halted.
- `ex_we_i` in 1: execute-stage register write enable, observed only.
- `ex_waddr_i` in 5: execute-stage write address, observed only.
- `jtag_we_o` out 1: register file JTAG write enable.
- `jtag_addr_o` out 5: register file JTAG read/write address.
- `jtag_data_o` out 32: register file JTAG write data.
- `jtag_data_i` in 32: register file JTAG read data (combinational from `jtag_addr_o`).

## Operation
- States: IDLE, HALT, ACCESS, RESP.
- Reset values: `req_ready_o`=0 during reset and 1 in IDLE afterwards. `resp_valid_o`=0, `resp_err_o`=0, `resp_data_o`=0, `halt_req_o`=0, `jtag_we_o`=0, `jtag_addr_o`=0, `jtag_data_o`=0. Retry and timeout counters are 0.
- IDLE:
  - `req_ready_o`=1.
  - On `req_valid_i & req_ready_o`, latch `req_we_i`, `req_addr_i` and `req_data_i`, then go to HALT.
- HALT:
  - `halt_req_o`=1.
  - If `halt_ack_i`=1, go to ACCESS.
  - Otherwise increment the timeout counter. When it reaches `HALT_TIMEOUT`, go to RESP with err=1.
- ACCESS:
  - `jtag_addr_o` = latched address throughout.
  - Read: capture `jtag_data_i` this cycle, go to RESP with err=0. Address 0 returns 0 regardless of `jtag_data_i`.
  - Write to address 0: no `jtag_we_o` pulse; go to RESP with err=0.
  - Write to a nonzero address: `jtag_we_o`=1 and `jtag_data_o` = latched data.
  - Write collision: the execute stage has priority on any nonzero write. The JTAG write is lost whenever `ex_we_i`=1 and `ex_waddr_i`≠0 in the same cycle.
    - No collision: go to RESP with err=0.
    - Collision: increment the retry counter and stay in ACCESS (re-pulse next cycle).
    - Collision when the counter already equals `RETRY_MAX`: go to RESP with err=1.
- RESP:
  - `resp_valid_o`=1; data and err are stable until the handshake.
  - On `resp_ready_i`=1, clear `resp_valid_o`, deassert `halt_req_o`, clear both counters, return to IDLE.
- `halt_req_o` stays 1 from HALT entry through the RESP handshake cycle.

## Timing
- Accept edge is cycle N; HALT is active in N+1.
- `halt_ack_i` already high: ACCESS in N+2, `resp_valid_o` in N+3.
- Each write collision adds 1 cycle.
- Minimum cycle rate: one command per 4 cycles (3 with the halt handshake compiled out).
- `jtag_we_o` is a registered output, asserted only while in ACCESS. It never stays high in any other state.
- `req_ready_o` is 0 from the accept edge until the cycle after the response handshake.
- `rst` asserted in any state: all outputs take their reset values at the next edge. The command in flight is dropped with no response, and `halt_req_o` drops.
- Request and response are never simultaneous; a new command is not accepted in the RESP handshake cycle.

## Configuration
- `JTAG_REG_ACCESS_HALT_EN` defined: HALT state and `halt_req_o`/`halt_ack_i` handshake as above.
- Not defined:
  - HALT is skipped (IDLE → ACCESS directly).
  - `halt_req_o` is tied to 0 and `halt_ack_i` is ignored.
  - The timeout error cannot occur.
  - Read latency is N+2 to `resp_valid_o`.

## Test plan
- Read x5 holding 0x1234_5678, `halt_ack_i`=1 → `jtag_addr_o`=5 in ACCESS. Response: data 0x1234_5678, err 0, `resp_valid_o` at N+3.
- Write x10=0xDEAD_BEEF, no ex activity → exactly one `jtag_we_o` pulse with addr 10 and data 0xDEAD_BEEF. Response: data echo, err 0.
- Write x3 while `ex_we_i`=1, `ex_waddr_i`=7 for 2 cycles → 3 `jtag_we_o` pulses; response err 0 at N+5.
- Write with `ex_we_i` held 1 (nonzero addr) and `RETRY_MAX`=15 → 16 pulses, then a response with err 1, data 0.
- `halt_ack_i` held 0 → error response after 255 HALT cycles. With the macro undefined, the same read completes at N+2 and `halt_req_o` stays 0.
- `rst` pulsed during ACCESS of a write → next edge: `jtag_we_o`=0, `halt_req_o`=0, no response, `req_ready_o`=1 after release. Write x0 → no pulse, err 0.

Source files
------------

// File: rtl/jtag_reg_access.sv
// -----------------------------------------------------------------------------
// jtag_reg_access
//
// Debug-side access controller for the general-purpose register file. Takes one
// read/write command at a time from the JTAG DTM, optionally halts the core,
// drives the register file's JTAG port, retries writes that lose to an
// execute-stage write, and returns exactly one response per command.
//
// Build option:
//   JTAG_REG_ACCESS_HALT_EN  defined   -> HALT state with halt_req_o/halt_ack_i
//                                          handshake and halt timeout.
//                            undefined -> IDLE goes straight to ACCESS,
//                                          halt_req_o tied to 0, halt_ack_i ignored.
//
// Parameters:
//   RETRY_MAX     write retries allowed after collisions before reporting error
//   HALT_TIMEOUT  HALT cycles to wait for halt_ack_i before reporting error
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_valid_i / req_ready_o  command handshake
//   req_we_i, req_addr_i,      command: 1 = write, register index, write data
//   req_data_i
//   resp_valid_o/resp_ready_i  response handshake
//   resp_data_o, resp_err_o    read data / write echo (0 on error), error flag
//   halt_req_o, halt_ack_i     core halt handshake
//   ex_we_i, ex_waddr_i        execute-stage write port (observed only)
//   jtag_we_o, jtag_addr_o,    register file JTAG port
//   jtag_data_o, jtag_data_i
// -----------------------------------------------------------------------------
module jtag_reg_access #(
  parameter int RETRY_MAX    = 15,
  parameter int HALT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [4:0]  req_addr_i,
  input  logic [31:0] req_data_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data_o,
  output logic        resp_err_o,
  output logic        halt_req_o,
  input  logic        halt_ack_i,
  input  logic        ex_we_i,
  input  logic [4:0]  ex_waddr_i,
  output logic        jtag_we_o,
  output logic [4:0]  jtag_addr_o,
  output logic [31:0] jtag_data_o,
  input  logic [31:0] jtag_data_i
);

  localparam int RETRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HALT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state_reg;
  logic                cmd_we_reg;
  logic [4:0]          cmd_addr_reg;
  logic [31:0]         cmd_data_reg;
  logic                req_ready_reg;
  logic                resp_valid_reg;
  logic [31:0]         resp_data_reg;
  logic                resp_err_reg;
  logic                jtag_we_reg;
  logic [4:0]          jtag_addr_reg;
  logic [31:0]         jtag_data_reg;
  logic [RETRY_W-1:0]  retry_cnt_reg;

`ifdef JTAG_REG_ACCESS_HALT_EN
  localparam int TMO_W = (HALT_TIMEOUT > 0) ? $clog2(HALT_TIMEOUT + 1) : 1;
  logic [TMO_W-1:0]    tmo_cnt_reg;
  logic                halt_req_reg;
`endif

  // The execute stage wins the register file write port whenever it writes a
  // real register; a write to x0 from the execute stage is no conflict.
  logic ex_collide;
  assign ex_collide = ex_we_i && (ex_waddr_i != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cmd_we_reg     <= 1'b0;
      cmd_addr_reg   <= 5'd0;
      cmd_data_reg   <= 32'd0;
      req_ready_reg  <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_data_reg  <= 32'd0;
      resp_err_reg   <= 1'b0;
      jtag_we_reg    <= 1'b0;
      jtag_addr_reg  <= 5'd0;
      jtag_data_reg  <= 32'd0;
      retry_cnt_reg  <= '0;
`ifdef JTAG_REG_ACCESS_HALT_EN
      tmo_cnt_reg    <= '0;
      halt_req_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          req_ready_reg <= 1'b1;
          if (req_valid_i && req_ready_reg) begin
            req_ready_reg <= 1'b0;
            cmd_we_reg    <= req_we_i;
            cmd_addr_reg  <= req_addr_i;
            cmd_data_reg  <= req_data_i;
`ifdef JTAG_REG_ACCESS_HALT_EN
            halt_req_reg  <= 1'b1;
            state_reg     <= HALT;
`else
            // No halt handshake: set up the register file port directly so
            // it is valid for the whole first ACCESS cycle.
            jtag_addr_reg <= req_addr_i;
            jtag_data_reg <= req_data_i;
            jtag_we_reg   <= req_we_i && (req_addr_i != 5'd0);
            state_reg     <= ACCESS;
`endif
          end
        end

`ifdef JTAG_REG_ACCESS_HALT_EN
        HALT: begin
          if (halt_ack_i) begin
            jtag_addr_reg <= cmd_addr_reg;
            jtag_data_reg <= cmd_data_reg;
            jtag_we_reg   <= cmd_we_reg && (cmd_addr_reg != 5'd0);
            state_reg     <= ACCESS;
          end else if (int'(tmo_cnt_reg) + 1 >= HALT_TIMEOUT) begin
            // This is the HALT_TIMEOUT-th cycle without an acknowledge.
            resp_valid_reg <= 1'b1;
            resp_data_reg  <= 32'd0;
            resp_err_reg   <= 1'b1;
            state_reg      <= RESP;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
          end
        end
`endif

        ACCESS: begin
          if (!cmd_we_reg) begin
            // Read data is combinational from jtag_addr_o; x0 always reads 0.
            resp_valid_reg <= 1'b1;
            resp_data_reg  <= (cmd_addr_reg == 5'd0) ? 32'd0 : jtag_data_i;
            resp_err_reg   <= 1'b0;
            state_reg      <= RESP;
          end else if (cmd_addr_reg == 5'd0) begin
            resp_valid_reg <= 1'b1;
            resp_data_reg  <= cmd_data_reg;
            resp_err_reg   <= 1'b0;
            state_reg      <= RESP;
          end else if (!ex_collide) begin
            jtag_we_reg    <= 1'b0;
            resp_valid_reg <= 1'b1;
            resp_data_reg  <= cmd_data_reg;
            resp_err_reg   <= 1'b0;
            state_reg      <= RESP;
          end else if (int'(retry_cnt_reg) >= RETRY_MAX) begin
            jtag_we_reg    <= 1'b0;
            resp_valid_reg <= 1'b1;
            resp_data_reg  <= 32'd0;
            resp_err_reg   <= 1'b1;
            state_reg      <= RESP;
          end else begin
            // Lost to the execute stage: keep jtag_we_o high to retry.
            retry_cnt_reg <= retry_cnt_reg + RETRY_W'(1);
          end
        end

        RESP: begin
          if (resp_ready_i) begin
            resp_valid_reg <= 1'b0;
            retry_cnt_reg  <= '0;
            req_ready_reg  <= 1'b1;
            state_reg      <= IDLE;
`ifdef JTAG_REG_ACCESS_HALT_EN
            halt_req_reg   <= 1'b0;
            tmo_cnt_reg    <= '0;
`endif
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_reg;
  assign resp_valid_o = resp_valid_reg;
  assign resp_data_o  = resp_data_reg;
  assign resp_err_o   = resp_err_reg;
  assign jtag_we_o    = jtag_we_reg;
  assign jtag_addr_o  = jtag_addr_reg;
  assign jtag_data_o  = jtag_data_reg;

`ifdef JTAG_REG_ACCESS_HALT_EN
  assign halt_req_o = halt_req_reg;
`else
  assign halt_req_o = 1'b0;
  // Halt acknowledge and timeout are meaningless without the halt handshake.
  logic unused_halt;
  assign unused_halt = halt_ack_i ^ (HALT_TIMEOUT == 0);
`endif

endmodule

// File: tb/tb_jtag_reg_access.sv
// -----------------------------------------------------------------------------
// tb_jtag_reg_access
//
// Self-checking bench for jtag_reg_access. Expected latency, jtag_we_o pulse
// count, response data and error flag for every command are computed from the
// command, the halt-acknowledge delay and the number of colliding
// execute-stage cycles. A behavioural register-file image tracks what reads
// must return. Works with JTAG_REG_ACCESS_HALT_EN defined or undefined.
// -----------------------------------------------------------------------------
module tb_jtag_reg_access;

  localparam int RETRY_MAX = 15;
  localparam int HALT_TO   = 255;
`ifdef JTAG_REG_ACCESS_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [4:0]  req_addr_i;
  logic [31:0] req_data_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_data_o;
  logic        resp_err_o;
  logic        halt_req_o;
  logic        halt_ack_i;
  logic        ex_we_i;
  logic [4:0]  ex_waddr_i;
  logic        jtag_we_o;
  logic [4:0]  jtag_addr_o;
  logic [31:0] jtag_data_o;
  logic [31:0] jtag_data_i;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int last_accept = 0;

  // Environment register file (what the core holds) and the reference image.
  logic [31:0] rf [32];
  logic [31:0] exp_rf [32];
  logic        load_en;
  logic [4:0]  load_addr;
  logic [31:0] load_data;

  jtag_reg_access #(
    .RETRY_MAX    (RETRY_MAX),
    .HALT_TIMEOUT (HALT_TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_data_i   (req_data_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_data_o  (resp_data_o),
    .resp_err_o   (resp_err_o),
    .halt_req_o   (halt_req_o),
    .halt_ack_i   (halt_ack_i),
    .ex_we_i      (ex_we_i),
    .ex_waddr_i   (ex_waddr_i),
    .jtag_we_o    (jtag_we_o),
    .jtag_addr_o  (jtag_addr_o),
    .jtag_data_o  (jtag_data_o),
    .jtag_data_i  (jtag_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file JTAG port: the execute stage owns the write port when it
  // writes a nonzero register; x0 is never written.
  always @(posedge clk) begin
    if (load_en)
      rf[load_addr] <= load_data;
    else if (jtag_we_o && !(ex_we_i && ex_waddr_i != 5'd0) && jtag_addr_o != 5'd0)
      rf[jtag_addr_o] <= jtag_data_o;
  end

  assign jtag_data_i = rf[jtag_addr_o];

  // One command end to end. d = cycles halt_ack_i stays low in HALT,
  // n_coll = colliding execute-stage cycles at the start of ACCESS.
  task automatic run_cmd(input logic we, input logic [4:0] addr, input logic [31:0] data,
                         input int d, input int n_coll, input int resp_delay);
    int          acc_start, exp_pulses, exp_k, pulses, k, w;
    bit          timed_out, seen;
    logic        exp_err;
    logic [31:0] exp_data;

    // Reference: expected behaviour from the command rules.
    timed_out = HALT_EN && (d >= HALT_TO);
    acc_start = HALT_EN ? (2 + d) : 1;
    if (timed_out) begin
      exp_pulses = 0; exp_err = 1'b1; exp_data = 32'd0; exp_k = 1 + HALT_TO;
    end else if (we && addr != 5'd0) begin
      if (n_coll > RETRY_MAX) begin
        exp_pulses = RETRY_MAX + 1; exp_err = 1'b1; exp_data = 32'd0;
      end else begin
        exp_pulses = n_coll + 1; exp_err = 1'b0; exp_data = data;
        exp_rf[addr] = data;
      end
      exp_k = acc_start + exp_pulses;
    end else begin
      exp_pulses = 0; exp_err = 1'b0;
      exp_data = we ? data : ((addr == 5'd0) ? 32'd0 : exp_rf[addr]);
      exp_k = acc_start + 1;
    end

    for (w = 0; w < 20 && req_ready_o !== 1'b1; w++) @(negedge clk);
    vectors++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_wait: got %b expected 1", req_ready_o);
    end
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_data_i  = data;
    last_accept = cyc + 1;

    seen = 1'b0;
    pulses = 0;
    for (k = 1; k <= 400 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid_i = 1'b0;
        req_we_i    = 1'($urandom);
        req_addr_i  = 5'($urandom);
        req_data_i  = $urandom;
        vectors++;
        if (req_ready_o !== 1'b0) begin
          errors++;
          $display("FAIL req_ready_busy: got %b expected 0", req_ready_o);
        end
      end
      vectors++;
      if (halt_req_o !== HALT_EN) begin
        errors++;
        $display("FAIL halt_req: cycle %0d got %b expected %b", k, halt_req_o, HALT_EN);
      end
      if (resp_valid_o === 1'b1) begin
        seen = 1'b1;
        vectors += 5;
        if (k != exp_k) begin
          errors++;
          $display("FAIL latency: got N+%0d expected N+%0d", k, exp_k);
        end
        if (resp_data_o !== exp_data) begin
          errors++;
          $display("FAIL resp_data: got %h expected %h", resp_data_o, exp_data);
        end
        if (resp_err_o !== exp_err) begin
          errors++;
          $display("FAIL resp_err: got %b expected %b", resp_err_o, exp_err);
        end
        if (pulses != exp_pulses) begin
          errors++;
          $display("FAIL we_pulses: got %0d expected %0d", pulses, exp_pulses);
        end
        if (jtag_we_o !== 1'b0) begin
          errors++;
          $display("FAIL we_in_resp: got %b expected 0", jtag_we_o);
        end
      end else begin
        if (jtag_we_o === 1'b1) begin
          pulses++;
          vectors += 2;
          if (jtag_addr_o !== addr) begin
            errors++;
            $display("FAIL we_addr: got %0d expected %0d", jtag_addr_o, addr);
          end
          if (jtag_data_o !== data) begin
            errors++;
            $display("FAIL we_data: got %h expected %h", jtag_data_o, data);
          end
        end
        if (!timed_out && k == acc_start) begin
          vectors++;
          if (jtag_addr_o !== addr) begin
            errors++;
            $display("FAIL access_addr: got %0d expected %0d", jtag_addr_o, addr);
          end
        end
      end
      // Inputs for the coming edge.
      if (HALT_EN) halt_ack_i = (k >= 1 + d);
      else         halt_ack_i = (d >= HALT_TO) ? 1'b0 : 1'($urandom);
      if (k >= acc_start && k < acc_start + n_coll) begin
        ex_we_i = 1'b1; ex_waddr_i = 5'($urandom_range(1, 31));
      end else if (k < acc_start) begin
        ex_we_i = 1'($urandom); ex_waddr_i = 5'($urandom);
      end else begin
        ex_we_i = 1'($urandom); ex_waddr_i = 5'd0;
      end
    end

    if (!seen) begin
      vectors++;
      errors++;
      $display("FAIL resp_timeout: no response within 400 cycles");
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      halt_ack_i = 1'b0; ex_we_i = 1'b0;
      @(negedge clk);
      return;
    end

    resp_ready_i = (resp_delay == 0);
    for (w = 0; w < resp_delay; w++) begin
      @(negedge clk);
      vectors += 2;
      if (resp_valid_o !== 1'b1) begin
        errors++;
        $display("FAIL resp_hold_valid: got %b expected 1", resp_valid_o);
      end
      if (resp_data_o !== exp_data || resp_err_o !== exp_err) begin
        errors++;
        $display("FAIL resp_hold: got %h/%b expected %h/%b", resp_data_o, resp_err_o, exp_data, exp_err);
      end
      if (w == resp_delay - 1) resp_ready_i = 1'b1;
    end
    @(negedge clk);
    resp_ready_i = 1'b0;
    halt_ack_i   = 1'b0;
    ex_we_i      = 1'b0;
    vectors += 3;
    if (resp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL resp_clear: got %b expected 0", resp_valid_o);
    end
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_resp: got %b expected 1", req_ready_o);
    end
    if (halt_req_o !== 1'b0) begin
      errors++;
      $display("FAIL halt_drop: got %b expected 0", halt_req_o);
    end
    $display("txn we=%0d addr=%0d data=%h d=%0d coll=%0d resp=%h err=%0d pulses=%0d",
             we, addr, data, d, n_coll, exp_data, exp_err, pulses);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = 5'd0; req_data_i = 32'd0;
    resp_ready_i = 1'b0; halt_ack_i = 1'b0; ex_we_i = 1'b0; ex_waddr_i = 5'd0;
    load_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      load_addr = 5'(i);
      load_data = (i == 0) ? 32'hFFFF_FFFF : (i == 5) ? 32'h1234_5678 : $urandom;
      exp_rf[i] = load_data;
    end
    @(negedge clk);
    load_en = 1'b0;
    vectors += 8;
    if (req_ready_o !== 1'b0)   begin errors++; $display("FAIL rst_req_ready: got %b expected 0", req_ready_o); end
    if (resp_valid_o !== 1'b0)  begin errors++; $display("FAIL rst_resp_valid: got %b expected 0", resp_valid_o); end
    if (resp_err_o !== 1'b0)    begin errors++; $display("FAIL rst_resp_err: got %b expected 0", resp_err_o); end
    if (resp_data_o !== 32'd0)  begin errors++; $display("FAIL rst_resp_data: got %h expected 0", resp_data_o); end
    if (halt_req_o !== 1'b0)    begin errors++; $display("FAIL rst_halt_req: got %b expected 0", halt_req_o); end
    if (jtag_we_o !== 1'b0)     begin errors++; $display("FAIL rst_jtag_we: got %b expected 0", jtag_we_o); end
    if (jtag_addr_o !== 5'd0)   begin errors++; $display("FAIL rst_jtag_addr: got %0d expected 0", jtag_addr_o); end
    if (jtag_data_o !== 32'd0)  begin errors++; $display("FAIL rst_jtag_data: got %h expected 0", jtag_data_o); end
    rst = 1'b0;
    for (int w = 0; w < 4 && req_ready_o !== 1'b1; w++) @(negedge clk);
    vectors++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", req_ready_o); end
  endtask

  task automatic test_read_basic();
    run_cmd(1'b0, 5'd5, 32'd0, 0, 0, 0);
    run_cmd(1'b0, 5'd5, 32'd0, 2, 0, 2);
  endtask

  task automatic test_write_basic();
    run_cmd(1'b1, 5'd10, 32'hDEAD_BEEF, 0, 0, 0);
    run_cmd(1'b0, 5'd10, 32'd0, 0, 0, 1);
  endtask

  task automatic test_collision();
    run_cmd(1'b1, 5'd3, 32'hA5A5_0003, 0, 2, 0);
    run_cmd(1'b0, 5'd3, 32'd0, 0, 0, 0);
  endtask

  task automatic test_retry_exhaust();
    run_cmd(1'b1, 5'd7, 32'h0BAD_0007, 0, RETRY_MAX, 0);
    run_cmd(1'b1, 5'd7, 32'hCAFE_0007, 1, RETRY_MAX + 1, 1);
    run_cmd(1'b0, 5'd7, 32'd0, 0, 0, 0);
  endtask

  task automatic test_halt_timeout();
    run_cmd(1'b0, 5'd12, 32'd0, HALT_TO, 0, 1);
    run_cmd(1'b0, 5'd12, 32'd0, HALT_TO - 1, 0, 0);
  endtask

  task automatic test_write_x0();
    run_cmd(1'b1, 5'd0, 32'h5555_AAAA, 0, 0, 0);
    run_cmd(1'b0, 5'd0, 32'd0, 0, 0, 0);
  endtask

  task automatic test_reset_midflight();
    for (int w = 0; w < 20 && req_ready_o !== 1'b1; w++) @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 5'd9; req_data_i = 32'h9999_0009;
    halt_ack_i = 1'b1; ex_we_i = 1'b1; ex_waddr_i = 5'd4;
    @(negedge clk);
    req_valid_i = 1'b0;
    for (int w = 0; w < 6 && jtag_we_o !== 1'b1; w++) @(negedge clk);
    vectors++;
    if (jtag_we_o !== 1'b1) begin errors++; $display("FAIL midflight_access: got %b expected 1", jtag_we_o); end
    rst = 1'b1;
    @(negedge clk);
    vectors += 4;
    if (jtag_we_o !== 1'b0)    begin errors++; $display("FAIL midrst_jtag_we: got %b expected 0", jtag_we_o); end
    if (halt_req_o !== 1'b0)   begin errors++; $display("FAIL midrst_halt_req: got %b expected 0", halt_req_o); end
    if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_resp_valid: got %b expected 0", resp_valid_o); end
    if (req_ready_o !== 1'b0)  begin errors++; $display("FAIL midrst_req_ready: got %b expected 0", req_ready_o); end
    rst = 1'b0; halt_ack_i = 1'b0; ex_we_i = 1'b0;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      vectors++;
      if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_no_resp: got %b expected 0", resp_valid_o); end
    end
    vectors++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", req_ready_o); end
    $display("txn reset during write x9 access, command dropped");
    run_cmd(1'b0, 5'd9, 32'd0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    int prev;
    int gap;
    gap = HALT_EN ? 4 : 3;
    run_cmd(1'b0, 5'd1, 32'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      prev = last_accept;
      run_cmd(1'($urandom), 5'($urandom_range(1, 31)), $urandom, 0, 0, 0);
      vectors++;
      if (last_accept - prev != gap) begin
        errors++;
        $display("FAIL cmd_rate: got %0d cycles expected %0d", last_accept - prev, gap);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic        we;
      logic [4:0]  addr;
      int          n_coll;
      we     = 1'($urandom);
      addr   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      n_coll = ($urandom_range(0, 9) == 0) ? $urandom_range(RETRY_MAX, RETRY_MAX + 2)
                                           : $urandom_range(0, 3);
      run_cmd(we, addr, $urandom, $urandom_range(0, 3), n_coll, $urandom_range(0, 2));
    end
  endtask

  initial begin
    load_en = 1'b0; load_addr = 5'd0; load_data = 32'd0;
    test_reset();
    test_read_basic();
    test_write_basic();
    test_collision();
    test_retry_exhaust();
    test_halt_timeout();
    test_write_x0();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
